// File: rtl/bless_age_router.sv
// Bufferless deflection router, 5 ports (N,E,S,W,Local), oldest-first allocation.
// Latency: control word 1 cycle, data word 1 cycle after its control word.
// Backpressure: none on network ports (never dropped); port4_ready flags accepted injection.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   portN_ci / portN_co  28-bit control word in / registered out (N = 0..4)
//   portN_di / portN_do  128-bit data word in / registered out, one cycle behind control
//   port4_ready          combinational: valid port4_ci accepted this cycle
module bless_age_router #(
   parameter int MY_X = 0,
   parameter int MY_Y = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [27:0]   port0_ci,
   input  logic [27:0]   port1_ci,
   input  logic [27:0]   port2_ci,
   input  logic [27:0]   port3_ci,
   input  logic [27:0]   port4_ci,
   output logic [27:0]   port0_co,
   output logic [27:0]   port1_co,
   output logic [27:0]   port2_co,
   output logic [27:0]   port3_co,
   output logic [27:0]   port4_co,
   input  logic [127:0]  port0_di,
   input  logic [127:0]  port1_di,
   input  logic [127:0]  port2_di,
   input  logic [127:0]  port3_di,
   input  logic [127:0]  port4_di,
   output logic [127:0]  port0_do,
   output logic [127:0]  port1_do,
   output logic [127:0]  port2_do,
   output logic [127:0]  port3_do,
   output logic [127:0]  port4_do,
   output logic          port4_ready
);

   localparam logic [3:0] MX = MY_X[3:0];
   localparam logic [3:0] MY = MY_Y[3:0];

   logic [27:0]  ci [5];
   logic [127:0] di [5];

   assign ci[0] = port0_ci;
   assign ci[1] = port1_ci;
   assign ci[2] = port2_ci;
   assign ci[3] = port3_ci;
   assign ci[4] = port4_ci;
   assign di[0] = port0_di;
   assign di[1] = port1_di;
   assign di[2] = port2_di;
   assign di[3] = port3_di;
   assign di[4] = port4_di;

   // XY dimension-order route: resolve X first, then Y, else local.
   function automatic logic [2:0] xy_route(input logic [7:0] dst);
      logic [3:0] dx;
      logic [3:0] dy;
      dx = dst[7:4];
      dy = dst[3:0];
      if (dx > MX)      xy_route = 3'd1;
      else if (dx < MX) xy_route = 3'd3;
      else if (dy > MY) xy_route = 3'd2;
      else if (dy < MY) xy_route = 3'd0;
      else              xy_route = 3'd4;
   endfunction

   // Lowest-index free network output; callers guarantee one exists.
   function automatic logic [2:0] lowest_free(input logic [4:0] busy);
      lowest_free = 3'd0;
      for (int k = 3; k >= 0; k--) begin
         if (!busy[k]) lowest_free = k[2:0];
      end
   endfunction

   logic [4:0]  vld;
   logic [10:0] age   [5];
   logic [2:0]  route [5];
   logic [2:0]  rank  [4];

   always_comb begin
      for (int i = 0; i < 5; i++) begin
         vld[i]   = ci[i][27];
         age[i]   = ci[i][26:16];
         route[i] = xy_route(ci[i][7:0]);
      end
   end

   // Priority rank among valid network inputs: 0 is the winner.
   // A flit outranks another if older, or equally old on a lower port.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         rank[i] = 3'd0;
         for (int j = 0; j < 4; j++) begin
            if (j != i && vld[j] &&
                (age[j] > age[i] || (age[j] == age[i] && j < i)))
               rank[i] = rank[i] + 3'd1;
         end
      end
   end

   logic [4:0] busy;
   logic [4:0] out_vld;
   logic [2:0] out_src [5];
   logic       ejected;
   logic [2:0] sel;

   // Allocation in rank order. Network flits always fit: at most four
   // of them compete for outputs 0-3 and only one can take output 4.
   always_comb begin
      busy        = 5'b0;
      out_vld     = 5'b0;
      ejected     = 1'b0;
      sel         = 3'd0;
      port4_ready = 1'b0;
      for (int o = 0; o < 5; o++) out_src[o] = 3'd0;

      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 4; i++) begin
            if (vld[i] && rank[i] == r[2:0]) begin
               if (route[i] == 3'd4 && !ejected) begin
                  sel     = 3'd4;
                  ejected = 1'b1;
               end else if (route[i] != 3'd4 && !busy[route[i]]) begin
                  sel = route[i];
               end else begin
                  sel = lowest_free(busy);
               end
               busy[sel]    = 1'b1;
               out_vld[sel] = 1'b1;
               out_src[sel] = i[2:0];
            end
         end
      end

      // Injection only into a leftover network output; never ejects.
      if (vld[4] && !(&busy[3:0])) begin
         port4_ready = 1'b1;
         if (route[4] != 3'd4 && !busy[route[4]]) sel = route[4];
         else                                     sel = lowest_free(busy);
         busy[sel]    = 1'b1;
         out_vld[sel] = 1'b1;
         out_src[sel] = 3'd4;
      end
   end

   logic [27:0]  co_d     [5];
   logic [27:0]  co_q     [5];
   logic         map_vld_q[5];
   logic [2:0]   map_src_q[5];
   logic [127:0] do_q     [5];
   logic [10:0]  age_inc;

   always_comb begin
      age_inc = 11'd0;
      for (int o = 0; o < 5; o++) begin
         co_d[o] = 28'd0;
         if (out_vld[o]) begin
            age_inc = (age[out_src[o]] == 11'h7FF) ? 11'h7FF : age[out_src[o]] + 11'd1;
            co_d[o] = {1'b1, age_inc, ci[out_src[o]][15:0]};
         end
      end
   end

   // Control and data pipelines are independent: the map registered with
   // a control word steers the data beat arriving on the following cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int o = 0; o < 5; o++) begin
            co_q[o]      <= 28'd0;
            map_vld_q[o] <= 1'b0;
            map_src_q[o] <= 3'd0;
            do_q[o]      <= 128'd0;
         end
      end else begin
         for (int o = 0; o < 5; o++) begin
            co_q[o]      <= co_d[o];
            map_vld_q[o] <= out_vld[o];
            map_src_q[o] <= out_src[o];
            do_q[o]      <= map_vld_q[o] ? di[map_src_q[o]] : 128'd0;
         end
      end
   end

   assign port0_co = co_q[0];
   assign port1_co = co_q[1];
   assign port2_co = co_q[2];
   assign port3_co = co_q[3];
   assign port4_co = co_q[4];
   assign port0_do = do_q[0];
   assign port1_do = do_q[1];
   assign port2_do = do_q[2];
   assign port3_do = do_q[3];
   assign port4_do = do_q[4];

endmodule

// File: tb/tb_bless_age_router.sv
module tb_bless_age_router;

   logic          clk = 1'b0;
   logic          rst;
   logic [27:0]   ci [5];
   logic [127:0]  di [5];
   wire  [27:0]   co [5];
   wire  [127:0]  dout [5];
   wire           port4_ready;

   int vectors    = 0;
   int miscompares = 0;

   localparam logic [127:0] DA = 128'h0123456789abcdef0123456789abcdef;
   localparam logic [127:0] DB = 128'hfedcba9876543210fedcba9876543210;
   localparam logic [127:0] DC = 128'h11112222333344445555666677778888;
   localparam logic [127:0] DD = 128'h9999aaaabbbbccccddddeeeeffff0000;

   always #5 clk = ~clk;

   bless_age_router #(.MY_X(0), .MY_Y(0)) dut (
      .clk(clk), .rst(rst),
      .port0_ci(ci[0]), .port1_ci(ci[1]), .port2_ci(ci[2]), .port3_ci(ci[3]), .port4_ci(ci[4]),
      .port0_co(co[0]), .port1_co(co[1]), .port2_co(co[2]), .port3_co(co[3]), .port4_co(co[4]),
      .port0_di(di[0]), .port1_di(di[1]), .port2_di(di[2]), .port3_di(di[3]), .port4_di(di[4]),
      .port0_do(dout[0]), .port1_do(dout[1]), .port2_do(dout[2]), .port3_do(dout[3]), .port4_do(dout[4]),
      .port4_ready(port4_ready)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_co(input string tag, input logic [27:0] e0, input logic [27:0] e1,
                         input logic [27:0] e2, input logic [27:0] e3, input logic [27:0] e4);
      logic [27:0] e [5];
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
      for (int i = 0; i < 5; i++)
         chk($sformatf("%s co%0d", tag, i), {100'd0, co[i]}, {100'd0, e[i]});
   endtask

   task automatic chk_do(input string tag, input logic [127:0] e0, input logic [127:0] e1,
                         input logic [127:0] e2, input logic [127:0] e3, input logic [127:0] e4);
      logic [127:0] e [5];
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
      for (int i = 0; i < 5; i++)
         chk($sformatf("%s do%0d", tag, i), dout[i], e[i]);
   endtask

   task automatic clear_in();
      for (int i = 0; i < 5; i++) begin
         ci[i] = 28'd0;
         di[i] = 128'd0;
      end
   endtask

   // Advance one rising edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      clear_in();
      tick();
      chk_co("reset", 0, 0, 0, 0, 0);
      chk_do("reset", 0, 0, 0, 0, 0);
      chk("reset ready", {127'd0, port4_ready}, 128'd0);
      rst = 1'b0;

      // Single flit to South, data one cycle behind.
      ci[0] = 28'h8000001;
      tick();
      chk_co("single e1", 0, 0, 28'h8010001, 0, 0);
      chk_do("single e1", 0, 0, 0, 0, 0);
      clear_in();
      di[0] = DA;
      tick();
      chk_co("single e2", 0, 0, 0, 0, 0);
      chk_do("single e2", 0, 0, DA, 0, 0);
      clear_in();
      tick();
      chk_co("single e3", 0, 0, 0, 0, 0);
      chk_do("single e3", 0, 0, 0, 0, 0);

      // Ejection of a local flit.
      ci[1] = 28'h8050000;
      tick();
      chk_co("eject", 0, 0, 0, 0, 28'h8060000);
      clear_in();
      di[1] = DB;
      tick();
      chk_do("eject", 0, 0, 0, 0, DB);
      clear_in();

      // Contention for South: older port1 wins, port0 deflected to port0.
      ci[0] = 28'h8030001;
      ci[1] = 28'h8070001;
      tick();
      chk_co("contend", 28'h8040001, 0, 28'h8080001, 0, 0);
      clear_in();
      di[0] = DA;
      di[1] = DB;
      tick();
      chk_do("contend", DA, 0, DB, 0, 0);
      clear_in();

      // Equal-age tie for East: port0 wins, port3 deflected to port0.
      ci[0] = 28'h8000A10;
      ci[3] = 28'h8000B10;
      tick();
      chk_co("tie", 28'h8010B10, 28'h8010A10, 0, 0, 0);
      clear_in();
      di[0] = DC;
      di[3] = DD;
      tick();
      chk_do("tie", DD, DC, 0, 0, 0);
      clear_in();

      // Injection blocked by four network flits.
      ci[0] = 28'h8000010;
      ci[1] = 28'h8000110;
      ci[2] = 28'h8000210;
      ci[3] = 28'h8000310;
      ci[4] = 28'h8000401;
      #1;
      chk("inj blocked ready", {127'd0, port4_ready}, 128'd0);
      tick();
      chk_co("inj blocked", 28'h8010110, 28'h8010010, 28'h8010210, 28'h8010310, 0);

      // Three network flits: injection lands on the one free port (3).
      ci[3] = 28'd0;
      #1;
      chk("inj ok ready", {127'd0, port4_ready}, 128'd1);
      tick();
      chk_co("inj ok", 28'h8010110, 28'h8010010, 28'h8010210, 28'h8010401, 0);
      clear_in();
      di[4] = DC;
      tick();
      chk_do("inj ok", 0, 0, 0, DC, 0);
      clear_in();

      // Lone injection takes its productive port.
      ci[4] = 28'h8000401;
      #1;
      chk("inj alone ready", {127'd0, port4_ready}, 128'd1);
      tick();
      chk_co("inj alone", 0, 0, 28'h8010401, 0, 0);
      clear_in();

      // Age saturation.
      ci[0] = 28'hFFF0001;
      tick();
      chk_co("age sat", 0, 0, 28'hFFF0001, 0, 0);
      clear_in();
      tick();

      // Reset with data in flight; ready stays combinational during reset.
      ci[0] = 28'h8000001;
      tick();
      chk_co("pre-rst", 0, 0, 28'h8010001, 0, 0);
      clear_in();
      di[0] = DA;
      ci[1] = 28'h8000010;
      ci[4] = 28'h8000401;
      rst = 1'b1;
      #1;
      chk("rst ready", {127'd0, port4_ready}, 128'd1);
      tick();
      chk_co("rst", 0, 0, 0, 0, 0);
      chk_do("rst", 0, 0, 0, 0, 0);
      rst = 1'b0;
      clear_in();
      tick();
      chk_co("post-rst", 0, 0, 0, 0, 0);
      chk_do("post-rst", 0, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
